// File: rtl/elvm_cpu_pkg.sv
// Shared definitions for the ELVM-style CPU: instruction field positions,
// opcode values and the instruction-fetch state encoding.
package elvm_cpu_pkg;

    localparam int unsigned INSTR_BITS = 42;

    // Instruction word layout
    localparam int unsigned IMM_BIT   = 41;
    localparam int unsigned OPC_MSB   = 40;
    localparam int unsigned OPC_LSB   = 36;
    localparam int unsigned OPA_MSB   = 35;
    localparam int unsigned OPA_LSB   = 28;
    localparam int unsigned SRC_MSB   = 27;
    localparam int unsigned SRC_LSB   = 25;
    localparam int unsigned SPARE_BIT = 24;
    localparam int unsigned IMMV_MSB  = 23;
    localparam int unsigned IMMV_LSB  = 0;

    localparam int unsigned OPC_W = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_ADD   = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_STORE = 5'b00100;
    localparam logic [OPC_W-1:0] OP_OUTS  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_EXIT  = 5'b11111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_BITS-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational program ROM
// and presents each word to decode through a one-entry valid/ready buffer.
module rom_fetch_ctrl
    import elvm_cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 42,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [4:0]        HALT_OP  = 5'b11111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_dout,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               running,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic               load;
    logic               is_halt;

    assign is_halt = (rom_dout[OPC_MSB:OPC_LSB] == HALT_OP);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end

            FETCH: begin
                load = (!instr_valid_q || instr_ready) && !redirect_valid;
                // Redirect voids any handshake or load in the same cycle
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_addr;
                end else if (load) begin
                    instr_d       = rom_dout;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    if (fetch_count_q != '1) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                    if (is_halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                end
            end

            HALTED: begin
                if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;
    assign running     = (state_q == FETCH);
    assign halted      = (state_q == HALTED);

endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 42-bit × 256-entry program ROM.
- Owns the 8-bit program counter and drives the ROM address. The ROM is combinational, so data is valid in the same cycle.
- Registers the returned word into a one-entry instruction buffer and hands it to decode over a valid/ready handshake.
- Handles start, branch redirect from execute, and halt on the exit opcode.

Parameters:
- ADDR_W, 8, ROM address / PC width.
- INSTR_W, 42, ROM word width.
- RESET_PC, 8'h00, PC value loaded at reset and on start.
- HALT_OP, 5'b11111, opcode field value that stops fetching.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins fetching from RESET_PC; honoured only in IDLE.
- rom_addr  out  ADDR_W  address to the ROM, equal to the current PC.
- rom_dout  in  INSTR_W  ROM word for rom_addr, same cycle.
- instr  out  INSTR_W  buffered instruction word.
- instr_pc  out  ADDR_W  address the buffered instruction was fetched from.
- instr_valid  out  1  buffer holds a valid instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- redirect_valid  in  1  execute requests a PC change.
- redirect_addr  in  ADDR_W  new PC.
- running  out  1  state is FETCH.
- halted  out  1  state is HALTED.
- fetch_count  out  16  number of instructions loaded into the buffer, saturating at 16'hFFFF.

Behaviour:
- Instruction field layout: [41] immediate flag, [40:36] opcode, [35:28] operand A, [27:25] source register, [24] spare, [23:0] immediate. This block decodes only [40:36].
- Reset, applied on the rising clk edge while rst=1:
  - state=IDLE, pc=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0.
  - running=0, halted=0, fetch_count=0.
  - Reset takes priority over every other input and may arrive mid-fetch, mid-stall or in HALTED; any buffered instruction is discarded.
- rom_addr is always pc. It is combinational from the pc register.
- States and transitions:
  - IDLE: no fetch. start=1 moves to FETCH next cycle with pc=RESET_PC. Redirect is ignored.
  - FETCH: in each cycle, "load" = (instr_valid==0 || instr_ready==1) && redirect_valid==0.
    - On load: instr<=rom_dout, instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo 256 (255 wraps to 0), fetch_count increments.
    - On load, if rom_dout[40:36]==HALT_OP: pc is held instead of incremented, and state<=HALTED.
    - No load because ready is low and redirect is idle: instr, instr_pc, instr_valid and pc are all held (stall).
    - A handshake without a new load (impossible in FETCH unless redirected) clears instr_valid.
  - HALTED:
    - No fetch. The buffered halt instruction stays presented until instr_ready, then instr_valid<=0.
    - redirect_valid and start are ignored.
    - Only rst leaves HALTED.
- Redirect (FETCH only) has priority over load and over handshake:
  - instr_valid<=0 and pc<=redirect_addr.
  - A transfer asserted in the same cycle is void; decode must discard it.
  - Latency: redirect at cycle N gives rom_addr=target at N+1 and instr_valid=1 with rom[target] at N+2.
- Start latency: start at cycle N gives state FETCH at N+1 and the first instruction valid at N+2.
- Throughput: with instr_ready held at 1, one instruction per cycle.
- While instr_valid=1 and instr_ready=0, instr and instr_pc are stable.
- Outputs are registered, except rom_addr, running and halted, which decode state/pc directly.
- fetch_count does not wrap; it holds at 16'hFFFF.

Decomposition:
- A shared package elvm_cpu_pkg holds:
  - the instruction field position constants (IMM_BIT, OPC_MSB/LSB, OPA_MSB/LSB, SRC_MSB/LSB, IMMV_MSB/LSB);
  - the opcode constants (OP_ADD=5'b00001, OP_LOAD=5'b00011, OP_STORE=5'b00100, OP_OUTS=5'b00101, OP_EXIT=HALT_OP);
  - the fetch state encoding (IDLE=2'd0, FETCH=2'd1, HALTED=2'd2).
- No sub-module is needed. The ROM stays a separate instance in the top level, connected through rom_addr/rom_dout.

Test Plan:
- Start and stream: ROM 0..3 non-halt, instr_ready=1, start pulse at cycle 2 → instr_valid rises at cycle 4; instr_pc=0,1,2,3 on consecutive cycles; fetch_count=4 after 4 loads.
- Stall: instr_ready=0 for 3 cycles while instr_pc=5 → instr, instr_pc=5 and rom_addr=6 held; after release, instr_pc=6 next cycle with no skip or duplicate.
- Redirect: redirect_valid=1 with redirect_addr=8'h40 at cycle N while valid and ready are both 1 → instr_valid=0 at N+1 with rom_addr=8'h40; instr_pc=8'h40 with rom[8'h40] at N+2.
- Wrap: run from pc=8'hFE → instr_pc sequence FE, FF, 00; fetch_count continues incrementing.
- Halt: rom[3] opcode=5'b11111 → the halt instruction is presented with halted=1, rom_addr stays 3, no further loads; redirect and start during HALTED have no effect; instr_valid=0 after acceptance.
- Reset mid-stall: rst=1 while instr_valid=1 and instr_ready=0 → next cycle all outputs are at reset values and state is IDLE; a subsequent start fetches from RESET_PC.
